// File: rtl/dn_ct_sched.sv
// dn_ct_sched: round-robin scheduler sharing one loadable down counter among N_REQ requesters.
// Optional COUNT-phase watchdog enabled by defining DN_CT_SCHED_WDOG_EN.
module dn_ct_sched #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned WIDTH = 3
) (
    input  logic                   clk,
    input  logic                   areset_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]       grant,
    output logic [N_REQ-1:0]       done,
    output logic                   busy,
    output logic                   err,
    output logic                   ct_load,
    output logic [WIDTH-1:0]       ct_data,
    input  logic [WIDTH-1:0]       ct_q
);
    localparam int unsigned PTR_W = $clog2(N_REQ);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_COUNT = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]       r_state,   w_nxt_state;
    logic [PTR_W-1:0] r_owner,   w_nxt_owner;
    logic [PTR_W-1:0] r_ptr,     w_nxt_ptr;
    logic [PTR_W-1:0] w_owner_inc, w_win, w_idx;
    logic             w_found;
    logic [N_REQ-1:0] r_grant,   w_nxt_grant;
    logic [N_REQ-1:0] r_done,    w_nxt_done;
    logic             r_busy;
    logic             r_ct_load, w_nxt_ct_load;
    logic [WIDTH-1:0] r_ct_data, w_nxt_ct_data;
    logic [WIDTH-1:0] w_slice [N_REQ];

`ifdef DN_CT_SCHED_WDOG_EN
    localparam int unsigned       WD_W    = WIDTH + 1;
    localparam logic [WD_W-1:0]   WD_LAST = WD_W'((1 << WIDTH) + 1);
    logic [WD_W-1:0] r_wd, w_nxt_wd;
    logic            r_err, w_nxt_err;
    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    assign grant   = r_grant;
    assign done    = r_done;
    assign busy    = r_busy;
    assign ct_load = r_ct_load;
    assign ct_data = r_ct_data;

    for (genvar g = 0; g < N_REQ; g++) begin : g_slice
        assign w_slice[g] = req_data[g*WIDTH +: WIDTH];
    end

    assign w_owner_inc = (r_owner == PTR_W'(N_REQ - 1)) ? '0 : r_owner + PTR_W'(1);

    // First requester at or above the rr pointer, wrapping
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            w_idx = PTR_W'((32'(r_ptr) + i) % N_REQ);
            if (!w_found && req[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    always_comb begin
        w_nxt_state   = r_state;
        w_nxt_owner   = r_owner;
        w_nxt_ptr     = r_ptr;
        w_nxt_grant   = r_grant;
        w_nxt_done    = '0;
        w_nxt_ct_load = 1'b0;
        w_nxt_ct_data = r_ct_data;
`ifdef DN_CT_SCHED_WDOG_EN
        w_nxt_wd      = r_wd;
        w_nxt_err     = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_nxt_state   = S_LOAD;
                    w_nxt_owner   = w_win;
                    w_nxt_grant   = N_REQ'(1) << w_win;
                    w_nxt_ct_load = 1'b1;
                    w_nxt_ct_data = w_slice[w_win];
                end
            end
            S_LOAD: begin
                w_nxt_state = S_COUNT;
`ifdef DN_CT_SCHED_WDOG_EN
                w_nxt_wd    = '0;
`endif
            end
            S_COUNT: begin
                // Owner withdrawal wins over completion in the same cycle
                if (!req[r_owner]) begin
                    w_nxt_state = S_IDLE;
                    w_nxt_grant = '0;
                    w_nxt_ptr   = w_owner_inc;
                end else if (ct_q == '0) begin
                    w_nxt_state = S_DONE;
                    w_nxt_done  = r_grant;
                end
`ifdef DN_CT_SCHED_WDOG_EN
                else if (r_wd == WD_LAST) begin
                    w_nxt_state = S_IDLE;
                    w_nxt_grant = '0;
                    w_nxt_ptr   = w_owner_inc;
                    w_nxt_err   = 1'b1;
                end else begin
                    w_nxt_wd = r_wd + WD_W'(1);
                end
`endif
            end
            default: begin
                w_nxt_state = S_IDLE;
                w_nxt_grant = '0;
                w_nxt_ptr   = w_owner_inc;
            end
        endcase
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            r_state   <= S_IDLE;
            r_owner   <= '0;
            r_ptr     <= '0;
            r_grant   <= '0;
            r_done    <= '0;
            r_busy    <= 1'b0;
            r_ct_load <= 1'b0;
            r_ct_data <= '0;
`ifdef DN_CT_SCHED_WDOG_EN
            r_wd      <= '0;
            r_err     <= 1'b0;
`endif
        end else begin
            r_state   <= w_nxt_state;
            r_owner   <= w_nxt_owner;
            r_ptr     <= w_nxt_ptr;
            r_grant   <= w_nxt_grant;
            r_done    <= w_nxt_done;
            r_busy    <= (w_nxt_state != S_IDLE);
            r_ct_load <= w_nxt_ct_load;
            r_ct_data <= w_nxt_ct_data;
`ifdef DN_CT_SCHED_WDOG_EN
            r_wd      <= w_nxt_wd;
            r_err     <= w_nxt_err;
`endif
        end
    end

endmodule

// File: tb/tb_dn_ct_sched.sv
// Self-checking bench for dn_ct_sched: directed job table, corner sequences, random run vs. job-timeline model.
module tb_dn_ct_sched;
    localparam int unsigned N = 4;
    localparam int unsigned W = 3;

    logic           clk;
    logic           areset_n;
    logic [N-1:0]   req;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   grant;
    logic [N-1:0]   done;
    logic           busy;
    logic           err;
    logic           ct_load;
    logic [W-1:0]   ct_data;
    logic [W-1:0]   ct_q;
    logic [W-1:0]   cnt_q;
    logic [W-1:0]   force_val;
    logic           force_en;

    int n_chk;
    int n_fail;

    // Reference model: current job as (owner, age since first grant cycle, start value)
    int           m_owner;
    int           m_age;
    int           m_v;
    int           m_ptr;
    logic [W-1:0] m_data;

    typedef struct {
        logic [N-1:0] req;
        logic [W-1:0] val;
        logic [N-1:0] exp_g;
        int           exp_at;
    } vec_t;

    vec_t tbl [6];

    dn_ct_sched #(.N_REQ(N), .WIDTH(W)) u_dut (
        .clk      (clk),
        .areset_n (areset_n),
        .req      (req),
        .req_data (req_data),
        .grant    (grant),
        .done     (done),
        .busy     (busy),
        .err      (err),
        .ct_load  (ct_load),
        .ct_data  (ct_data),
        .ct_q     (ct_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The shared down counter the scheduler drives
    always @(posedge clk or negedge areset_n) begin
        if (!areset_n)          cnt_q <= '0;
        else if (ct_load)       cnt_q <= ct_data;
        else if (cnt_q != '0)   cnt_q <= cnt_q - W'(1);
    end
    assign ct_q = force_en ? force_val : cnt_q;

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timed out");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_grant"},   32'(grant),   0);
        chk({name, "_done"},    32'(done),    0);
        chk({name, "_busy"},    32'(busy),    0);
        chk({name, "_err"},     32'(err),     0);
        chk({name, "_ct_load"}, 32'(ct_load), 0);
        chk({name, "_ct_data"}, 32'(ct_data), 0);
    endtask

    function automatic logic [N*W-1:0] rep(input logic [W-1:0] v);
        logic [N*W-1:0] r;
        r = {N{v}};
        return r;
    endfunction

    task automatic wait_grant(input string name);
        int n;
        n = 0;
        while (grant == '0 && n < 40) begin
            step();
            n++;
        end
        chk({name, "_grant_rise"}, 32'(grant != '0), 1);
    endtask

    // Follow one grant from rise to fall; returns at the first sample with grant low
    task automatic serve(output int gap, output logic [N-1:0] g, output int len,
                         output int ndone, output int done_at, output logic bad,
                         output logic ld, output logic [W-1:0] dat);
        gap = 0; len = 0; ndone = 0; done_at = -1; bad = 1'b0; g = '0; ld = 1'b0; dat = '0;
        while (grant == '0 && gap < 60) begin
            step();
            gap++;
        end
        chk("serve_grant_seen", 32'(grant != '0), 1);
        if (grant == '0) return;
        g   = grant;
        ld  = ct_load;
        dat = ct_data;
        while (grant != '0 && len < 60) begin
            if (grant !== g || busy !== 1'b1 || err !== 1'b0) bad = 1'b1;
            if (done != '0) begin
                ndone++;
                done_at = len;
                if (done !== g) bad = 1'b1;
            end
            len++;
            step();
        end
    endtask

    task automatic model_step(input logic [N-1:0] r, input logic [N*W-1:0] d);
        int c;
        if (m_owner < 0) begin
            for (int k = 0; k < int'(N); k++) begin
                c = (m_ptr + k) % int'(N);
                if (m_owner < 0 && ((r >> c) & N'(1)) != '0) begin
                    m_owner = c;
                    m_age   = 0;
                    m_data  = W'(d >> (c * int'(W)));
                    m_v     = int'(m_data);
                end
            end
        end else if (m_age >= 1 && m_age <= m_v + 1 && ((r >> m_owner) & N'(1)) == '0) begin
            m_ptr   = (m_owner + 1) % int'(N);
            m_owner = -1;
        end else if (m_age == m_v + 2) begin
            m_ptr   = (m_owner + 1) % int'(N);
            m_owner = -1;
        end else begin
            m_age++;
        end
    endtask

    initial begin
        int           gap, len, ndone, done_at, bad_cnt;
        logic [N-1:0] g, bm, nr, exp_g, exp_d;
        logic         bad, ld;
        logic [W-1:0] dat;
        logic [N-1:0] order [5];

        n_chk = 0; n_fail = 0;
        areset_n = 1'b0; req = '0; req_data = '0; force_en = 1'b0; force_val = '0;

        tbl[0] = '{4'b0001, 3'd6, 4'b0001, 8};
        tbl[1] = '{4'b0100, 3'd0, 4'b0100, 2};
        tbl[2] = '{4'b1010, 3'd3, 4'b1000, 5};
        tbl[3] = '{4'b1010, 3'd1, 4'b0010, 3};
        tbl[4] = '{4'b0011, 3'd7, 4'b0001, 9};
        tbl[5] = '{4'b1111, 3'd5, 4'b0010, 7};

        step(); step();
        chk_zero("reset");
        areset_n = 1'b1;
        step();
        chk_zero("idle");

        // Single jobs; rr pointer advances past each owner
        foreach (tbl[i]) begin
            req_data = rep(tbl[i].val);
            req      = tbl[i].req;
            serve(gap, g, len, ndone, done_at, bad, ld, dat);
            chk("tbl_grant",   32'(g),   32'(tbl[i].exp_g));
            chk("tbl_ct_load", 32'(ld),  1);
            chk("tbl_ct_data", 32'(dat), 32'(tbl[i].val));
            chk("tbl_done_at", 32'(done_at), 32'(tbl[i].exp_at));
            chk("tbl_len",     32'(len),     32'(tbl[i].exp_at + 1));
            chk("tbl_ndone",   32'(ndone),   1);
            chk("tbl_clean",   32'(bad),     0);
            req = '0;
            chk("tbl_busy_off", 32'(busy), 0);
            step();
        end

        // Reset mid-COUNT drops the job; rotation restarts from requester 0
        req_data = rep(3'd4);
        req      = 4'b0101;
        wait_grant("rst");
        chk("rst_first_grant", 32'(grant), 32'(4'b0100));
        step(); step(); step();
        areset_n = 1'b0;
        #1;
        chk_zero("reset_mid");
        areset_n = 1'b1;
        serve(gap, g, len, ndone, done_at, bad, ld, dat);
        chk("rst_after_grant0", 32'(g), 32'(4'b0001));
        chk("rst_after_ndone",  32'(ndone), 1);
        serve(gap, g, len, ndone, done_at, bad, ld, dat);
        chk("rst_after_grant2", 32'(g), 32'(4'b0100));
        chk("rst_after_gap",    32'(gap), 1);
        req = '0;
        step();

        // All four requesting: strict rotation with one idle cycle between grants
        areset_n = 1'b0;
        step();
        areset_n = 1'b1;
        order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b0100;
        order[3] = 4'b1000; order[4] = 4'b0001;
        req_data = rep(3'd2);
        req      = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            serve(gap, g, len, ndone, done_at, bad, ld, dat);
            chk("rr_grant",   32'(g),       32'(order[k]));
            chk("rr_len",     32'(len),     5);
            chk("rr_ndone",   32'(ndone),   1);
            chk("rr_done_at", 32'(done_at), 4);
            chk("rr_clean",   32'(bad),     0);
            if (k > 0) chk("rr_gap", 32'(gap), 1);
            if (k == 4) req = '0;
        end
        step();

        // Owner withdraws on its third COUNT cycle
        req_data = {3'd0, 3'd0, 3'd7, 3'd1};
        req      = 4'b0011;
        wait_grant("abort");
        chk("abort_grant1", 32'(grant), 32'(4'b0010));
        step(); step(); step();
        chk("abort_still_granted", 32'(grant), 32'(4'b0010));
        req = 4'b0001;
        step();
        chk("abort_grant_clear", 32'(grant), 0);
        chk("abort_no_done",     32'(done),  0);
        chk("abort_busy",        32'(busy),  0);
        step();
        chk("abort_next_grant0", 32'(grant), 32'(4'b0001));
        serve(gap, g, len, ndone, done_at, bad, ld, dat);
        chk("abort_next_done_at", 32'(done_at), 3);
        chk("abort_next_ndone",   32'(ndone),   1);
        req = '0;
        step();

        // Counter stuck at a nonzero value
        force_en  = 1'b1;
        force_val = 3'd5;
        req_data  = rep(3'd3);
        req       = 4'b0010;
        wait_grant("stuck");
        chk("stuck_grant", 32'(grant), 32'(4'b0010));
        bad_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (grant !== 4'b0010 || err !== 1'b0 || done !== '0 || busy !== 1'b1) bad_cnt++;
        end
        chk("stuck_count_phase", 32'(bad_cnt), 0);
        step();
`ifdef DN_CT_SCHED_WDOG_EN
        chk("wdog_err",   32'(err),   1);
        chk("wdog_grant", 32'(grant), 0);
        chk("wdog_busy",  32'(busy),  0);
        chk("wdog_done",  32'(done),  0);
        step();
        chk("wdog_err_pulse", 32'(err), 0);
`else
        bad_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            if (busy !== 1'b1 || err !== 1'b0 || grant !== 4'b0010 || done !== '0) bad_cnt++;
            step();
        end
        chk("stuck_waits", 32'(bad_cnt), 0);
`endif
        req = '0;
        step(); step(); step();
        chk("stuck_release_busy",  32'(busy),  0);
        chk("stuck_release_grant", 32'(grant), 0);
        force_en = 1'b0;

        // Random traffic against the job-timeline model
        areset_n = 1'b0;
        step();
        areset_n = 1'b1;
        m_owner = -1; m_age = 0; m_v = 0; m_ptr = 0; m_data = '0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            nr = req;
            for (int i = 0; i < int'(N); i++) begin
                bm = N'(1) << i;
                if ((req & bm) == '0) begin
                    if ($urandom_range(0, 3) == 0) nr = nr | bm;
                end else if (i == m_owner) begin
                    if (m_age == m_v + 2) begin
                        if ($urandom_range(0, 1) == 0) nr = nr & ~bm;
                    end else if ($urandom_range(0, 19) == 0) begin
                        nr = nr & ~bm;
                    end
                end else if ($urandom_range(0, 29) == 0) begin
                    nr = nr & ~bm;
                end
            end
            req      = nr;
            req_data = (N*W)'($urandom);
            step();
            model_step(nr, req_data);
            exp_g = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
            exp_d = (m_owner >= 0 && m_age == m_v + 2) ? exp_g : '0;
            chk("rand_grant",   32'(grant),   32'(exp_g));
            chk("rand_done",    32'(done),    32'(exp_d));
            chk("rand_busy",    32'(busy),    32'(m_owner >= 0));
            chk("rand_ct_load", 32'(ct_load), 32'(m_owner >= 0 && m_age == 0));
            chk("rand_ct_data", 32'(ct_data), 32'(m_data));
            chk("rand_err",     32'(err),     0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dn_ct_sched.md
Name: dn_ct_sched

Overview:
- Round-robin scheduler that shares one loadable WIDTH-bit down counter (clk, load, data, q) among N_REQ requesters.
- Each requester supplies a start value. The block grants one requester, pulses the counter load with that value, and watches q until it reaches 0.
- It then pulses done to that requester and serves the next one.
- Sits between requester logic and a single shared down-counter instance.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- WIDTH, 3, counter and start-value width

Ports:
- clk  input  1  system clock, rising edge
- areset_n  input  1  asynchronous active-low reset
- req  input  N_REQ  per-requester request; held high until done
- req_data  input  N_REQ*WIDTH  start values; requester i uses bits [i*WIDTH +: WIDTH]
- grant  output  N_REQ  one-hot owner of the counter, registered
- done  output  N_REQ  one-cycle completion pulse to the owner
- busy  output  1  high whenever the state is not IDLE
- err  output  1  one-cycle watchdog pulse (see Optional Feature)
- ct_load  output  1  load strobe to the shared counter
- ct_data  output  WIDTH  load value to the shared counter
- ct_q  input  WIDTH  shared counter output

Behaviour:
- Reset (areset_n low, asynchronous): state=IDLE, grant=0, done=0, busy=0, err=0, ct_load=0, ct_data=0, rr pointer=0.
- Reset mid-operation: everything returns to reset values immediately; the active job is dropped with no done.
- States: IDLE, LOAD, COUNT, DONE.
- IDLE -> LOAD when any req bit is high.
  - Winner = first set req bit searching upward from the rr pointer, wrapping modulo N_REQ.
  - On this edge: grant[winner] set, req_data slice latched into ct_data.
  - Later changes to req_data are ignored.
- LOAD: ct_load=1 for exactly this one cycle, ct_data=latched value. Always -> COUNT.
- COUNT: ct_load=0.
  - If ct_q==0 -> DONE. The first COUNT cycle sees the loaded value, so a value of 0 goes straight to DONE.
  - Else stay in COUNT.
  - If req[owner] goes low while in COUNT -> abort: go to IDLE, clear grant, no done, pointer=owner+1.
  - Abort takes priority over ct_q==0 in the same cycle.
- DONE: done[owner]=1 for exactly one cycle, grant still held. Then -> IDLE with grant cleared and pointer=owner+1 mod N_REQ.
- Timing: grant is high from LOAD through DONE inclusive. With start value v, done occurs v+2 cycles after the first grant cycle.
- Service slot: v+3 cycles per job, plus one IDLE cycle before the next grant.
- At most one grant bit is high at any time. done is only ever asserted together with its own grant bit.
- req bits of non-owners are ignored until the scheduler returns to IDLE.
- A requester that keeps req high after done is re-eligible. Rotation still guarantees the others are served first.

Optional Feature:
- Macro: DN_CT_SCHED_WDOG_EN.
- Defined:
  - An internal counter runs in COUNT and clears on COUNT entry.
  - If COUNT lasts 2^WIDTH+2 cycles without ct_q==0: err=1 for one cycle, grant cleared, state -> IDLE, no done, pointer=owner+1.
- Not defined: err tied to 0; COUNT waits indefinitely.

Test Plan:
1. Release reset, req=0001, slice0=6 -> ct_load high for 1 cycle with ct_data=6. done[0] pulses 8 cycles after grant[0] rises. busy high for 9 cycles.
2. req=1111 held, all slices=2 -> grant order 0,1,2,3,0. Each grant lasts 5 cycles, with 1 IDLE cycle between grants. Exactly one done per grant.
3. slice2=0, req=0100 -> LOAD, one COUNT cycle, then DONE. done[2] pulses 2 cycles after grant[2] rises.
4. req=0011, slice1=7. req[1] dropped on its 3rd COUNT cycle -> no done[1], grant clears next edge. Then grant[0]=1 one IDLE cycle later.
5. areset_n pulled low mid-COUNT for 1 ns with req=0101 held -> all outputs 0 immediately. After release, grant[0] is served before grant[2].
6. DN_CT_SCHED_WDOG_EN defined, ct_q forced to 5 -> err pulses once after 10 COUNT cycles, no done, scheduler returns to IDLE. Without the macro, busy stays high.
